// File: rtl/loader_pkg.sv
// Shared types and constants for the memory loader.
// CHECKSUM_EN adds the CHECK state to the state encoding.
package loader_pkg;

    localparam int HEADER_BYTES = 4;

    typedef logic [31:0] word_t;

    // Five states do not fit two bits, so the encoding is three bits wide.
    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_DATA   = 3'd1,
`ifdef CHECKSUM_EN
        ST_CHECK  = 3'd2,
`endif
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word packer. Byte i of a group lands in bits
// [8i+7:8i]. o_word shows the word including the byte accepted this cycle,
// so it is complete in the same cycle that o_complete pulses.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_accept,
    input  logic [7:0] i_byte,
    output word_t      o_word,
    output logic       o_complete,
    output logic [1:0] o_index
);

    logic [1:0] r_idx;
    word_t      r_buf;

    // Store each accepted byte in its lane and advance the index (wraps 3->0).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= 2'd0;
            r_buf <= '0;
        end else if (i_accept) begin
            r_buf[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx                       <= r_idx + 2'd1;
        end
    end

    // Bypass the incoming byte into its lane so the full word is visible now.
    always_comb begin
        o_word = r_buf;
        if (i_accept) begin
            o_word[{r_idx, 3'b000} +: 8] = i_byte;
        end
    end

    assign o_complete = i_accept && (r_idx == 2'(HEADER_BYTES - 1));
    assign o_index    = r_idx;

endmodule

// File: rtl/memory_loader.sv
// Bus initiator that loads a word count plus payload from a byte stream into
// memory starting at BASE_ADDR, then raises done (or error on a bad frame).
// Optional feature macro: CHECKSUM_EN (trailing 8-bit payload sum byte).
module memory_loader
    import loader_pkg::*;
#(
    parameter word_t WORD_NUM  = 32'd2048,
    parameter word_t BASE_ADDR = 32'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t     r_state, w_next;
    word_t      r_n;
    word_t      r_cnt;
    logic       r_we;
    word_t      r_addr;
    word_t      r_wdata;
    word_t      w_word;
    logic       w_complete;
    logic [1:0] w_index;
    logic       w_xfer;
    logic       w_pack_accept;
    logic       w_last_word;

    assign w_xfer        = rx_valid && rx_ready;
    assign w_pack_accept = w_xfer && (r_state == ST_HEADER || r_state == ST_DATA);
    assign w_last_word   = (r_cnt == r_n - 32'd1);

    byte_word_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_accept   (w_pack_accept),
        .i_byte     (rx_data),
        .o_word     (w_word),
        .o_complete (w_complete),
        .o_index    (w_index)
    );

`ifdef CHECKSUM_EN
    logic [7:0] r_sum;

    // Running mod-256 sum of payload bytes; header bytes are excluded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= 8'd0;
        end else if (r_state == ST_DATA && w_pack_accept) begin
            r_sum <= r_sum + rx_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HEADER;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (r_state)
            ST_HEADER: begin
                busy = (w_index != 2'd0);
                if (w_complete) begin
                    if (w_word == '0) begin
                        w_next = ST_DONE;
                    end else if (w_word > WORD_NUM) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                busy = 1'b1;
                if (w_complete && w_last_word) begin
`ifdef CHECKSUM_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef CHECKSUM_EN
            ST_CHECK: begin
                busy = 1'b1;
                if (w_xfer) begin
                    w_next = (rx_data == r_sum) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE: begin
                rx_ready = 1'b0;
                done     = 1'b1;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                w_next = ST_HEADER;
            end
        endcase
    end

    // Latch N from the header and issue one-cycle word writes in DATA.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_n     <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_state == ST_HEADER && w_complete) begin
                r_n   <= w_word;
                r_cnt <= '0;
            end
            if (r_state == ST_DATA && w_complete) begin
                r_we    <= 1'b1;
                r_addr  <= BASE_ADDR + r_cnt;
                r_wdata <= w_word;
                r_cnt   <= r_cnt + 32'd1;
            end
        end
    end

    assign mem_write_enable = r_we;
    assign mem_address      = r_addr;
    assign mem_write_data   = r_wdata;

endmodule
